// File: rtl/parking_lot_counter.sv
// Gate occupancy counter: synchronises two beam sensors, decodes the direction of a car
// passing through them, and keeps a saturating count of parked cars.
module parking_lot_counter #(
   parameter int unsigned MAX_COUNT = 25,
   parameter int unsigned CW        = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          A,
   input  logic          B,
   output logic [CW-1:0] COUNT,
   output logic          enter,
   output logic          exit,
   output logic          full,
   output logic          empty
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EN1      = 3'd1,
      EN2      = 3'd2,
      EN3      = 3'd3,
      EX1      = 3'd4,
      EX2      = 3'd5,
      EX3      = 3'd6,
      WAIT_CLR = 3'd7
   } state_e;

   localparam logic [CW-1:0] MaxCnt = CW'(MAX_COUNT);

   logic          a_meta_q, a_sync_q, b_meta_q, b_sync_q;
   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          enter_q, exit_q, full_q, empty_q;
   logic          inc_c, dec_c;
   logic [1:0]    ab_c;

   assign ab_c  = {a_sync_q, b_sync_q};
   assign COUNT = count_q;
   assign enter = enter_q;
   assign exit  = exit_q;
   assign full  = full_q;
   assign empty = empty_q;

   // Direction decoder: a legal pass walks through both beams in order; any jump parks in WAIT_CLR.
   always_comb begin
      state_d = state_q;
      inc_c   = 1'b0;
      dec_c   = 1'b0;
      case (state_q)
         IDLE: begin
            case (ab_c)
               2'b10:   state_d = EN1;
               2'b01:   state_d = EX1;
               2'b11:   state_d = WAIT_CLR;
               default: state_d = IDLE;
            endcase
         end
         EN1: begin
            case (ab_c)
               2'b11:   state_d = EN2;
               2'b00:   state_d = IDLE;
               2'b01:   state_d = WAIT_CLR;
               default: state_d = EN1;
            endcase
         end
         EN2: begin
            case (ab_c)
               2'b01:   state_d = EN3;
               2'b10:   state_d = EN1;
               2'b00:   state_d = WAIT_CLR;
               default: state_d = EN2;
            endcase
         end
         EN3: begin
            case (ab_c)
               2'b00: begin
                  state_d = IDLE;
                  inc_c   = 1'b1;
               end
               2'b11:   state_d = EN2;
               2'b10:   state_d = WAIT_CLR;
               default: state_d = EN3;
            endcase
         end
         EX1: begin
            case (ab_c)
               2'b11:   state_d = EX2;
               2'b00:   state_d = IDLE;
               2'b10:   state_d = WAIT_CLR;
               default: state_d = EX1;
            endcase
         end
         EX2: begin
            case (ab_c)
               2'b10:   state_d = EX3;
               2'b01:   state_d = EX1;
               2'b00:   state_d = WAIT_CLR;
               default: state_d = EX2;
            endcase
         end
         EX3: begin
            case (ab_c)
               2'b00: begin
                  state_d = IDLE;
                  dec_c   = 1'b1;
               end
               2'b11:   state_d = EX2;
               2'b01:   state_d = WAIT_CLR;
               default: state_d = EX3;
            endcase
         end
         default: begin
            if (ab_c == 2'b00) state_d = IDLE;
         end
      endcase
   end

   // Saturating count; the pulse still fires at the limits since a car physically passed.
   always_comb begin
      count_d = count_q;
      if (inc_c && (count_q < MaxCnt)) count_d = count_q + CW'(1);
      if (dec_c && (count_q != '0))    count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_meta_q <= 1'b0;
         a_sync_q <= 1'b0;
         b_meta_q <= 1'b0;
         b_sync_q <= 1'b0;
         state_q  <= IDLE;
         count_q  <= '0;
         enter_q  <= 1'b0;
         exit_q   <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         a_meta_q <= A;
         a_sync_q <= a_meta_q;
         b_meta_q <= B;
         b_sync_q <= b_meta_q;
         state_q  <= state_d;
         count_q  <= count_d;
         enter_q  <= inc_c;
         exit_q   <= dec_c;
         full_q   <= (count_d == MaxCnt);
         empty_q  <= (count_d == '0);
      end
   end

endmodule

// File: tb/tb_parking_lot_counter.sv
// Directed bench for parking_lot_counter: expected pulses are queued as sequences are driven
// and matched against pulses captured from the DUT.
module tb_parking_lot_counter;

   typedef struct packed {
      logic       en;
      logic       ex;
      logic [4:0] cnt;
   } ev_t;

   localparam int MAXC = 25;

   logic       clk = 1'b0;
   logic       reset_n, A, B;
   logic [4:0] COUNT;
   logic       enter, exit, full, empty;

   int  tests = 0;
   int  fails = 0;
   int  model = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];

   always #5 clk = ~clk;

   parking_lot_counter #(.MAX_COUNT(25), .CW(5)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .A      (A),
      .B      (B),
      .COUNT  (COUNT),
      .enter  (enter),
      .exit   (exit),
      .full   (full),
      .empty  (empty)
   );

   // Capture every pulse cycle together with the count visible alongside it.
   always @(negedge clk) begin
      if (enter || exit) obs_q.push_back(ev_t'{en: enter, ex: exit, cnt: COUNT});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [1:0] ab, input int n);
      {A, B} = ab;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_enter();
      if (model < MAXC) model++;
      exp_q.push_back(ev_t'{en: 1'b1, ex: 1'b0, cnt: 5'(model)});
   endtask

   task automatic push_exit();
      if (model > 0) model--;
      exp_q.push_back(ev_t'{en: 1'b0, ex: 1'b1, cnt: 5'(model)});
   endtask

   task automatic car_entry();
      step(2'b10, 4);
      step(2'b11, 4);
      step(2'b01, 4);
      push_enter();
      step(2'b00, 4);
   endtask

   task automatic car_exit();
      step(2'b01, 4);
      step(2'b11, 4);
      step(2'b10, 4);
      push_exit();
      step(2'b00, 4);
   endtask

   task automatic check_events(input string tag);
      ev_t e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : ev_t'(0);
         check({tag, "_pulse"}, 32'(o), 32'(e));
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         check({tag, "_extra_pulse"}, 32'(o), 32'(0));
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"}, 32'(COUNT), 32'(model));
      check({tag, "_full"},  32'(full),  32'(model == MAXC));
      check({tag, "_empty"}, 32'(empty), 32'(model == 0));
   endtask

   initial begin
      reset_n = 1'b0;
      A = 1'b1;
      B = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(COUNT), 32'(0));
      check("rst_empty", 32'(empty), 32'(1));
      check("rst_full",  32'(full),  32'(0));
      check("rst_enter", 32'(enter), 32'(0));
      check("rst_exit",  32'(exit),  32'(0));
      obs_q.delete();
      reset_n = 1'b1;
      step(2'b00, 6);
      check_events("post_rst");
      check_state("post_rst");

      // Single entry with exact latency from B falling to the count update.
      step(2'b10, 4);
      step(2'b11, 4);
      step(2'b01, 4);
      push_enter();
      {A, B} = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check("lat_count_early", 32'(COUNT), 32'(0));
      check("lat_enter_early", 32'(enter), 32'(0));
      @(posedge clk);
      #1;
      check("lat_count_edge3", 32'(COUNT), 32'(1));
      check("lat_enter_edge3", 32'(enter), 32'(1));
      @(posedge clk);
      #1;
      check("lat_enter_one_cycle", 32'(enter), 32'(0));
      step(2'b00, 2);
      check_events("entry1");
      check_state("entry1");

      // Entry aborted by reversing out of EN2.
      step(2'b10, 4);
      step(2'b11, 4);
      step(2'b10, 4);
      step(2'b00, 4);
      check_events("abort");
      check_state("abort");

      // Exit to zero, then an exit at zero keeps the pulse but not the decrement.
      car_exit();
      check_events("exit1");
      check_state("exit1");
      car_exit();
      check_events("exit_underflow");
      check_state("exit_underflow");

      // Fill to capacity, overflow attempt, then one exit.
      for (int i = 0; i < MAXC; i++) begin
         car_entry();
         check_events("fill");
      end
      check_state("fill_done");
      car_entry();
      check_events("overflow");
      check_state("overflow");
      car_exit();
      check_events("exit_from_full");
      check_state("exit_from_full");

      // Both beams at once, plus wandering while blocked, must not count.
      step(2'b11, 4);
      step(2'b01, 4);
      step(2'b11, 4);
      step(2'b10, 4);
      step(2'b00, 4);
      check_events("illegal");
      check_state("illegal");
      car_entry();
      check_events("after_illegal");
      check_state("after_illegal");

      // Walk down to 7, then reset while a car sits in EN2.
      while (model > 7) begin
         car_exit();
         check_events("drain");
      end
      check_state("at_seven");
      step(2'b10, 4);
      step(2'b11, 4);
      reset_n = 1'b0;
      {A, B} = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      model = 0;
      check_state("mid_rst");
      reset_n = 1'b1;
      step(2'b00, 6);
      check_events("mid_rst");
      check_state("post_mid_rst");
      car_entry();
      check_events("entry_after_rst");
      check_state("entry_after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
